// File: rtl/dmac_mem_responder_pkg.sv
// Shared types and constants for the DMAC memory responder.
package dmac_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int BUS_ADDR_W = 16;
    localparam int LAT_W      = 4;

    localparam logic [DATA_W-1:0] OOR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT,
        RELEASE
    } state_e;

endpackage

// File: rtl/dmac_mem_responder_ram.sv
// Single-port synchronous RAM; read data is registered and held until the next read.
module dmac_mem_ram
    import dmac_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        if (re) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmac_mem_responder.sv
// Bus-side responder for the DMAC master port: grant FSM plus a host-shared RAM.
// Optional bus-error reporting (m_err, err_cnt) is enabled by DMAC_MEM_BUSERR_EN.
module dmac_mem_responder
    import dmac_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int GRANT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_req,
    input  logic                  m_wr,
    input  logic [BUS_ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0]     m_dout,
    output logic                  m_grant,
    output logic [DATA_W-1:0]     m_din,
    input  logic                  h_en,
    input  logic                  h_wr,
    input  logic [ADDR_W-1:0]     h_addr,
    input  logic [DATA_W-1:0]     h_din,
    output logic [DATA_W-1:0]     h_dout,
    output logic                  h_busy
`ifdef DMAC_MEM_BUSERR_EN
    ,
    output logic                  m_err,
    output logic [7:0]            err_cnt
`endif
);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               m_rd_q, m_rd_d, m_oor_q, m_oor_d, h_rd_q, h_rd_d;
    logic [DATA_W-1:0]  m_din_hold_q, h_dout_hold_q;
    logic               dma_acc, dma_oor, sel_dma;
    logic               ram_we, ram_re;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata, ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: if (m_req) begin
                state_d = WAIT;
                cnt_d   = LAT_W'(GRANT_LAT - 1);
            end
            WAIT: if (!m_req) begin
                state_d = IDLE;
            end else if (cnt_q == '0) begin
                state_d = GRANT;
                grant_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            GRANT: if (!m_req) state_d = RELEASE;
                   else grant_d = 1'b1;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM belongs to the DMAC for the whole GRANT state, even on the cycle m_req drops.
    assign sel_dma = (state_q == GRANT);
    assign dma_acc = sel_dma && m_req;
    assign dma_oor = (m_addr >> ADDR_W) != '0;
    assign h_busy  = h_en && sel_dma;

    always_comb begin
        if (sel_dma) begin
            ram_we    = !reset && dma_acc && m_wr && !dma_oor;
            ram_re    = !reset && dma_acc && !m_wr && !dma_oor;
            ram_addr  = m_addr[ADDR_W-1:0];
            ram_wdata = m_dout;
        end else begin
            ram_we    = !reset && h_en && h_wr;
            ram_re    = !reset && h_en && !h_wr;
            ram_addr  = h_addr;
            ram_wdata = h_din;
        end
        m_rd_d  = dma_acc && !m_wr;
        m_oor_d = dma_oor;
        h_rd_d  = !sel_dma && h_en && !h_wr;
    end

    dmac_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= 1'b0;
            m_rd_q        <= 1'b0;
            m_oor_q       <= 1'b0;
            h_rd_q        <= 1'b0;
            m_din_hold_q  <= '0;
            h_dout_hold_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            m_rd_q        <= m_rd_d;
            m_oor_q       <= m_oor_d;
            h_rd_q        <= h_rd_d;
            m_din_hold_q  <= m_din;
            h_dout_hold_q <= h_dout;
        end
    end

    // Shared RAM output is steered to whichever port read last edge; otherwise each port holds.
    assign m_grant = grant_q;
    assign m_din   = m_rd_q ? (m_oor_q ? OOR_RDATA : ram_rdata) : m_din_hold_q;
    assign h_dout  = h_rd_q ? ram_rdata : h_dout_hold_q;

`ifdef DMAC_MEM_BUSERR_EN
    logic       m_err_q, m_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        m_err_d   = dma_acc && dma_oor;
        err_cnt_d = err_cnt_q;
        if (m_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            m_err_q   <= m_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_err   = m_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmac_mem_responder.sv
// Randomized bench for dmac_mem_responder with an in-bench behavioural model.
module tb_dmac_mem_responder;

    localparam int ADDR_W    = 8;
    localparam int GRANT_LAT = 2;
    localparam int DEPTH     = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset, m_req, m_wr, h_en, h_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout, m_din, h_din, h_dout;
    logic [7:0]  h_addr;
    logic        m_grant, h_busy;
`ifdef DMAC_MEM_BUSERR_EN
    logic        m_err;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    dmac_mem_responder #(.ADDR_W(ADDR_W), .GRANT_LAT(GRANT_LAT)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
        .m_grant(m_grant), .m_din(m_din),
        .h_en(h_en), .h_wr(h_wr), .h_addr(h_addr), .h_din(h_din),
        .h_dout(h_dout), .h_busy(h_busy)
`ifdef DMAC_MEM_BUSERR_EN
        , .m_err(m_err), .err_cnt(err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: memory image, grant tracked as "consecutive eligible request edges".
    logic [31:0] mem [DEPTH];
    bit          mg, rel;
    int          streak;
    logic [31:0] em_din, eh_dout;
    bit          e_err;
    int          e_cnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_edge();
        bit oor;
        if (reset) begin
            mg = 0; rel = 0; streak = 0;
            em_din = '0; eh_dout = '0; e_err = 0; e_cnt = 0;
            return;
        end
        e_err = 0;
        if (mg && m_req) begin
            oor = (m_addr[15:8] != 8'h00);
            if (m_wr) begin
                if (!oor) mem[m_addr[7:0]] = m_dout;
            end else begin
                em_din = oor ? 32'h0 : mem[m_addr[7:0]];
            end
            if (oor) begin
                e_err = 1;
                if (e_cnt < 255) e_cnt++;
            end
        end
        if (!mg && h_en) begin
            if (h_wr) mem[h_addr] = h_din;
            else      eh_dout = mem[h_addr];
        end
        if (mg) begin
            if (!m_req) begin mg = 0; rel = 1; end
        end else if (rel) begin
            rel = 0; streak = 0;
        end else if (m_req) begin
            streak++;
            if (streak == GRANT_LAT + 1) mg = 1;
        end else begin
            streak = 0;
        end
    endtask

    task automatic tick();
        #1 chk("h_busy", 32'(h_busy), 32'(h_en && mg));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("m_grant", 32'(m_grant), 32'(mg));
        chk("m_din", m_din, em_din);
        chk("h_dout", h_dout, eh_dout);
`ifdef DMAC_MEM_BUSERR_EN
        chk("m_err", 32'(m_err), 32'(e_err));
        chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
`endif
    endtask

    task automatic step(bit rq, bit wr, logic [15:0] a, logic [31:0] d,
                        bit he, bit hw, logic [7:0] ha, logic [31:0] hd, bit rs);
        m_req = rq; m_wr = wr; m_addr = a; m_dout = d;
        h_en = he; h_wr = hw; h_addr = ha; h_din = hd; reset = rs;
        tick();
    endtask

    task automatic host_op(bit rq, bit wr, logic [7:0] a, logic [31:0] d);
        step(rq, 1'b0, 16'h0, 32'h0, 1'b1, wr, a, d, 1'b0);
    endtask

    task automatic dma_op(bit wr, logic [15:0] a, logic [31:0] d);
        step(1'b1, wr, a, d, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    endtask

    task automatic idle(bit rq);
        step(rq, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] mem9;
        bit rq;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_reset_grant", 32'(m_grant), 32'h0);
        chk("lit_reset_mdin", m_din, 32'h0);
        chk("lit_reset_hdout", h_dout, 32'h0);

        for (int a = 0; a < DEPTH; a++) host_op(0, 1, 8'(a), $urandom);

        // Grant latency, DMAC readback of host data, DMAC write, out-of-range, collision.
        host_op(0, 1, 8'h05, 32'hDEAD_BEEF);
        idle(1); chk("lit_lat0", 32'(m_grant), 0);
        idle(1); chk("lit_lat1", 32'(m_grant), 0);
        idle(1); chk("lit_lat2", 32'(m_grant), 1);
        dma_op(0, 16'h0005, 32'h0);
        chk("lit_dma_rd", m_din, 32'hDEAD_BEEF);
        dma_op(1, 16'h0007, 32'h1234_5678);
        mem9 = mem[9];
        m_req = 1; m_wr = 0; h_en = 1; h_wr = 1; h_addr = 8'h09; h_din = 32'h5555_5555;
        #1 chk("lit_busy_grant", 32'(h_busy), 1);
        tick();
        dma_op(1, 16'h0105, 32'hAAAA_AAAA);
        dma_op(0, 16'h0105, 32'h0);
        chk("lit_oor_rd", m_din, 32'h0);
`ifdef DMAC_MEM_BUSERR_EN
        chk("lit_err_cnt", 32'(err_cnt), 32'd2);
`endif
        idle(0); chk("lit_release", 32'(m_grant), 0);
        idle(1); idle(1);
        idle(1); chk("lit_relat2", 32'(m_grant), 0);
        idle(1); chk("lit_relat3", 32'(m_grant), 1);
        idle(0); idle(0);
        host_op(0, 0, 8'h07, 0); chk("lit_host_rd7", h_dout, 32'h1234_5678);
        host_op(0, 0, 8'h05, 0); chk("lit_host_rd5", h_dout, 32'hDEAD_BEEF);
        host_op(0, 0, 8'h09, 0); chk("lit_busy_nowrite", h_dout, mem9);
        host_op(1, 1, 8'h09, 32'h5555_5555); chk("lit_busy_idle", 32'(h_busy), 0);
        idle(0); idle(0);
        host_op(0, 0, 8'h09, 0); chk("lit_host_rd9", h_dout, 32'h5555_5555);

        // Abort during WAIT, then reset while granted.
        idle(1); idle(0);
        for (int i = 0; i < 4; i++) begin idle(0); chk("lit_abort", 32'(m_grant), 0); end
        idle(1); idle(1); idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); chk("lit_rst_grant", 32'(m_grant), 0);
        idle(0);
        host_op(0, 0, 8'h07, 0); chk("lit_rst_keep", h_dout, 32'h1234_5678);

        // Random traffic.
        rq = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 7) == 0) rq = !rq;
            if ($urandom_range(0, 7) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
            else a = 16'($urandom_range(0, 15));
            step(rq, 1'($urandom), a, $urandom, 1'($urandom), 1'($urandom),
                 8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
